// File: rtl/thermo_setpoint_ctrl_pkg.sv
// Shared types, widths and saturating arithmetic for the thermostat setpoint controller.
package thermo_pkg;

  localparam int TEMP_W   = 8;
  localparam int DISP_MAX = 99;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  function automatic logic [TEMP_W-1:0] sat_inc(input logic [TEMP_W-1:0] v,
                                                input logic [TEMP_W-1:0] hi);
    return (v >= hi) ? hi : v + TEMP_W'(1);
  endfunction

  function automatic logic [TEMP_W-1:0] sat_dec(input logic [TEMP_W-1:0] v,
                                                input logic [TEMP_W-1:0] lo);
    return (v <= lo) ? lo : v - TEMP_W'(1);
  endfunction

endpackage

// File: rtl/thermo_setpoint_ctrl_if.sv
// Button/sensor inputs and display/actuator outputs of the thermostat core.
interface thermo_setpoint_ctrl_if;
  import thermo_pkg::*;

  logic              btn_up;
  logic              btn_down;
  logic              btn_set;
  logic              temp_valid;
  logic [TEMP_W-1:0] temp_in;
  logic [TEMP_W-1:0] disp_current;
  logic [TEMP_W-1:0] disp_changed;
  logic              heat_on;
  logic              cool_on;
  logic              editing;
  logic              disp_blank;

  modport master (
    output btn_up, btn_down, btn_set, temp_valid, temp_in,
    input  disp_current, disp_changed, heat_on, cool_on, editing, disp_blank
  );

  modport slave (
    input  btn_up, btn_down, btn_set, temp_valid, temp_in,
    output disp_current, disp_changed, heat_on, cool_on, editing, disp_blank
  );

endinterface

// File: rtl/thermo_timeout_timer.sv
// Loadable down-counter: reload starts a PERIOD-cycle count, clear stops it,
// expire pulses for one cycle while the running count sits at zero.
module thermo_timeout_timer #(
  parameter int unsigned PERIOD = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] count;
  logic             running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      running <= 1'b0;
    end else if (reload) begin
      count   <= CNT_W'(PERIOD - 1);
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - CNT_W'(1);
    end
  end

  assign expire = running && (count == '0);

endmodule

// File: rtl/thermo_setpoint_ctrl.sv
// Thermostat core: setpoint edit FSM with timeout, temperature sampling and
// hysteretic heat/cool requests. Optional edit blink under THERMO_BLINK_EN.
module thermo_setpoint_ctrl
  import thermo_pkg::*;
#(
  parameter int          TEMP_MIN     = 50,
  parameter int          TEMP_MAX     = 90,
  parameter int          TEMP_DEFAULT = 72,
  parameter int          HYST         = 2,
  parameter int unsigned TIMEOUT_CYC  = 500000000,
  parameter int unsigned BLINK_CYC    = 25000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  thermo_setpoint_ctrl_if.slave  io
);

  localparam logic [TEMP_W-1:0] T_MIN = TEMP_W'(TEMP_MIN);
  localparam logic [TEMP_W-1:0] T_MAX = TEMP_W'(TEMP_MAX);
  localparam logic [TEMP_W-1:0] T_DEF = TEMP_W'(TEMP_DEFAULT);

  state_t            state, state_nxt;
  logic [TEMP_W-1:0] setpoint, setpoint_nxt;
  logic [TEMP_W-1:0] pending, pending_nxt;
  logic [TEMP_W-1:0] cur_temp, cur_temp_nxt;
  logic [TEMP_W-1:0] disp_changed;
  logic              heat, cool, heat_nxt, cool_nxt;
  logic              tmr_reload, tmr_clear, tmr_expire;
  logic              up_only, down_only, press;
  logic              heat_want, cool_want;
  logic signed [TEMP_W:0] cur9, sp9, lo9, hi9;

  assign up_only   = io.btn_up & ~io.btn_down;
  assign down_only = io.btn_down & ~io.btn_up;
  assign press     = up_only | down_only;

  thermo_timeout_timer #(.PERIOD(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (tmr_reload),
    .clear  (tmr_clear),
    .expire (tmr_expire)
  );

  always_comb begin
    state_nxt    = state;
    setpoint_nxt = setpoint;
    pending_nxt  = pending;
    tmr_reload   = 1'b0;
    tmr_clear    = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt   = EDIT;
          pending_nxt = up_only ? sat_inc(setpoint, T_MAX) : sat_dec(setpoint, T_MIN);
          tmr_reload  = 1'b1;
        end
      end
      EDIT: begin
        // Commit outranks both a concurrent press and a concurrent timeout.
        if (io.btn_set) begin
          setpoint_nxt = pending;
          state_nxt    = IDLE;
          tmr_clear    = 1'b1;
        end else if (press) begin
          pending_nxt = up_only ? sat_inc(pending, T_MAX) : sat_dec(pending, T_MIN);
          tmr_reload  = 1'b1;
        end else if (tmr_expire) begin
          pending_nxt = setpoint;
          state_nxt   = IDLE;
          tmr_clear   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_temp_nxt = cur_temp;
    if (io.temp_valid)
      cur_temp_nxt = (io.temp_in > TEMP_W'(DISP_MAX)) ? TEMP_W'(DISP_MAX) : io.temp_in;
  end

  // Widened signed compare keeps setpoint-HYST meaningful for tiny setpoints.
  assign cur9 = $signed({1'b0, cur_temp});
  assign sp9  = $signed({1'b0, setpoint});
  assign lo9  = sp9 - $signed((TEMP_W+1)'(HYST));
  assign hi9  = sp9 + $signed((TEMP_W+1)'(HYST));

  assign heat_want = heat ? (cur9 < sp9) : (cur9 < lo9);
  assign cool_want = cool ? (cur9 > sp9) : (cur9 > hi9);
  assign heat_nxt  = heat_want & ~cool_want;
  assign cool_nxt  = cool_want & ~heat_want;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      setpoint     <= T_DEF;
      pending      <= T_DEF;
      cur_temp     <= T_DEF;
      disp_changed <= T_DEF;
      heat         <= 1'b0;
      cool         <= 1'b0;
    end else begin
      state        <= state_nxt;
      setpoint     <= setpoint_nxt;
      pending      <= pending_nxt;
      cur_temp     <= cur_temp_nxt;
      disp_changed <= (state_nxt == EDIT) ? pending_nxt : setpoint_nxt;
      heat         <= heat_nxt;
      cool         <= cool_nxt;
    end
  end

`ifdef THERMO_BLINK_EN
  logic blink_expire, blank;

  thermo_timeout_timer #(.PERIOD(BLINK_CYC)) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (tmr_reload | blink_expire),
    .clear  (tmr_clear),
    .expire (blink_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        blank <= 1'b0;
    else if (tmr_clear || tmr_reload)  blank <= 1'b0;
    else if (blink_expire)             blank <= ~blank;
  end

  assign io.disp_blank = blank;
`else
  assign io.disp_blank = 1'b0;
`endif

  assign io.disp_current = cur_temp;
  assign io.disp_changed = disp_changed;
  assign io.heat_on      = heat;
  assign io.cool_on      = cool;
  assign io.editing      = (state == EDIT);

endmodule

// File: tb/tb_thermo_setpoint_ctrl.sv
// Directed bench for thermo_setpoint_ctrl with shortened timeout (100 cycles).
module tb_thermo_setpoint_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [19:0] got, exp_v;

  thermo_setpoint_ctrl_if io();

  thermo_setpoint_ctrl #(
    .TEMP_MIN(50), .TEMP_MAX(90), .TEMP_DEFAULT(72), .HYST(2),
    .TIMEOUT_CYC(100), .BLINK_CYC(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  // Packed view: disp_current, disp_changed, heat, cool, editing, blank.
  function automatic logic [19:0] obs();
    return {io.disp_current, io.disp_changed, io.heat_on, io.cool_on, io.editing, io.disp_blank};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    io.btn_up = 0; io.btn_down = 0; io.btn_set = 0; io.temp_valid = 0; io.temp_in = 0;
    rst_n = 0;
    #12;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic drive(input logic up, input logic down, input logic set);
    io.btn_up = up; io.btn_down = down; io.btn_set = set;
    tick();
    io.btn_up = 0; io.btn_down = 0; io.btn_set = 0;
  endtask

  task automatic sample(input logic [7:0] t);
    io.temp_valid = 1; io.temp_in = t;
    tick();
    io.temp_valid = 0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    got = obs(); exp_v = {8'd72, 8'd72, 4'b0000}; total_cnt++;
    if (got !== exp_v) $display("FAIL reset_state got=%h exp=%h", got, exp_v); else pass_cnt++;
  endtask

  task automatic test_edit_commit();
    logic [7:0] e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      e = 8'(73 + i);
      got = obs(); exp_v = {8'd72, e, 4'b0010}; total_cnt++;
      if (got !== exp_v) $display("FAIL up_step%0d got=%h exp=%h", i, got, exp_v); else pass_cnt++;
    end
    drive(0, 0, 1);
    got = obs(); exp_v = {8'd72, 8'd75, 4'b0000}; total_cnt++;
    if (got !== exp_v) $display("FAIL commit got=%h exp=%h", got, exp_v); else pass_cnt++;
    tick();
    got = obs(); exp_v = {8'd72, 8'd75, 4'b1000}; total_cnt++;
    if (got !== exp_v) $display("FAIL heat_after_commit got=%h exp=%h", got, exp_v); else pass_cnt++;
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(1, 0, 0);
    got = obs(); exp_v = {8'd72, 8'd73, 4'b0010}; total_cnt++;
    if (got !== exp_v) $display("FAIL timeout_enter got=%h exp=%h", got, exp_v); else pass_cnt++;
    repeat (99) tick();
    got = obs(); exp_v = {8'd72, 8'd73, 4'b0010}; total_cnt++;
    if (got !== exp_v) $display("FAIL timeout_early got=%h exp=%h", got, exp_v); else pass_cnt++;
    tick();
    got = obs(); exp_v = {8'd72, 8'd72, 4'b0000}; total_cnt++;
    if (got !== exp_v) $display("FAIL timeout_discard got=%h exp=%h", got, exp_v); else pass_cnt++;
  endtask

  task automatic test_clamp();
    apply_reset();
    repeat (18) drive(1, 0, 0);
    drive(0, 0, 1);
    tick();
    got = obs(); exp_v = {8'd72, 8'd90, 4'b1000}; total_cnt++;
    if (got !== exp_v) $display("FAIL set_90 got=%h exp=%h", got, exp_v); else pass_cnt++;
    drive(1, 0, 0);
    drive(1, 0, 0);
    got = obs(); exp_v = {8'd72, 8'd90, 4'b1010}; total_cnt++;
    if (got !== exp_v) $display("FAIL clamp_max got=%h exp=%h", got, exp_v); else pass_cnt++;
    repeat (40) drive(0, 1, 0);
    drive(0, 0, 1);
    tick();
    got = obs(); exp_v = {8'd72, 8'd50, 4'b0100}; total_cnt++;
    if (got !== exp_v) $display("FAIL set_50 got=%h exp=%h", got, exp_v); else pass_cnt++;
    drive(0, 1, 0);
    got = obs(); exp_v = {8'd72, 8'd50, 4'b0110}; total_cnt++;
    if (got !== exp_v) $display("FAIL clamp_min got=%h exp=%h", got, exp_v); else pass_cnt++;
  endtask

  task automatic test_climate();
    logic [7:0] tv [5];
    logic [19:0] ev [5];
    tv = '{8'd75, 8'd73, 8'd72, 8'd69, 8'd120};
    ev = '{{8'd75, 8'd72, 4'b0100}, {8'd73, 8'd72, 4'b0100}, {8'd72, 8'd72, 4'b0000},
           {8'd69, 8'd72, 4'b1000}, {8'd99, 8'd72, 4'b0100}};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      sample(tv[i]);
      got = obs(); total_cnt++;
      if (got !== ev[i]) $display("FAIL climate_t%0d got=%h exp=%h", tv[i], got, ev[i]); else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    drive(1, 1, 0);
    got = obs(); exp_v = {8'd72, 8'd72, 4'b0000}; total_cnt++;
    if (got !== exp_v) $display("FAIL updown_idle got=%h exp=%h", got, exp_v); else pass_cnt++;
    drive(1, 0, 0);
    repeat (49) tick();
    drive(1, 1, 0);
    got = obs(); exp_v = {8'd72, 8'd73, 4'b0010}; total_cnt++;
    if (got !== exp_v) $display("FAIL updown_edit got=%h exp=%h", got, exp_v); else pass_cnt++;
    repeat (49) tick();
    tick();
    got = obs(); exp_v = {8'd72, 8'd72, 4'b0000}; total_cnt++;
    if (got !== exp_v) $display("FAIL updown_no_reload got=%h exp=%h", got, exp_v); else pass_cnt++;
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 1);
    got = obs(); exp_v = {8'd72, 8'd74, 4'b0000}; total_cnt++;
    if (got !== exp_v) $display("FAIL set_wins got=%h exp=%h", got, exp_v); else pass_cnt++;
  endtask

  task automatic test_reset_mid_edit();
    apply_reset();
    sample(8'd75);
    drive(1, 0, 0);
    got = obs(); exp_v = {8'd75, 8'd73, 4'b0110}; total_cnt++;
    if (got !== exp_v) $display("FAIL pre_reset got=%h exp=%h", got, exp_v); else pass_cnt++;
    rst_n = 0;
    #1;
    got = obs(); exp_v = {8'd72, 8'd72, 4'b0000}; total_cnt++;
    if (got !== exp_v) $display("FAIL async_reset got=%h exp=%h", got, exp_v); else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
    tick();
    got = obs(); total_cnt++;
    if (got !== exp_v) $display("FAIL post_reset got=%h exp=%h", got, exp_v); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_edit_commit();
    test_timeout();
    test_clamp();
    test_climate();
    test_simultaneous();
    test_reset_mid_edit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
